// File: rtl/sram_dat_pkg.sv
// Shared constants, FSM encoding and reset-map helper for the SRAM page-map controller.
package sram_dat_pkg;

  localparam logic [15:0] DAT_BASE = 16'hFFE0;
  localparam int unsigned PPN_W    = 7;
  localparam int unsigned SRAM_AW  = PPN_W + 12;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe
  } dat_state_e;

  // Identity map: logical page i -> physical page i.
  function automatic logic [PPN_W-1:0] dat_reset_ppn(input logic [3:0] idx);
    return PPN_W'(idx);
  endfunction

endpackage

// File: rtl/sram_dat_ctrl_if.sv
// CPU-side and SRAM-side signal bundle of the page-map controller.
interface sram_dat_ctrl_if;
  import sram_dat_pkg::*;

  logic               cpu_phase;
  logic [15:0]        cpu_addr;
  logic               cpu_rw;
  logic [7:0]         cpu_dout;
  logic               ext_sel;
  logic [7:0]         sram_rdata;

  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic [7:0]         sram_wdata;
  logic               sram_wdata_oe;
  logic [7:0]         cpu_rdata;
  logic               dat_hit;
  logic [7:0]         dat_dout;

  modport master (
    output cpu_phase, cpu_addr, cpu_rw, cpu_dout, ext_sel, sram_rdata,
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata, sram_wdata_oe,
    input  cpu_rdata, dat_hit, dat_dout
  );

  modport slave (
    input  cpu_phase, cpu_addr, cpu_rw, cpu_dout, ext_sel, sram_rdata,
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata, sram_wdata_oe,
    output cpu_rdata, dat_hit, dat_dout
  );

endinterface

// File: rtl/dat_map_file.sv
// 16-entry page-map register file: one synchronous write port, two async read ports,
// synchronous reset to the identity map.
module dat_map_file
  import sram_dat_pkg::*;
#(
  parameter int unsigned PpnW = PPN_W
) (
  input  logic            clk_i,
  input  logic            n_reset_i,
  input  logic            we_i,
  input  logic [3:0]      waddr_i,
  input  logic [PpnW-1:0] wdata_i,
  input  logic [3:0]      tr_idx_i,
  output logic [PpnW-1:0] tr_ppn_o,
  input  logic [3:0]      rb_idx_i,
  output logic [PpnW-1:0] rb_ppn_o
);

  logic [PpnW-1:0] map_q [16];

  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      for (int i = 0; i < 16; i++) begin
        map_q[i] <= PpnW'(dat_reset_ppn(4'(i)));
      end
    end else if (we_i) begin
      map_q[waddr_i] <= wdata_i;
    end
  end

  assign tr_ppn_o = map_q[tr_idx_i];
  assign rb_ppn_o = map_q[rb_idx_i];

endmodule

// File: rtl/sram_dat_ctrl.sv
// CPU-to-SRAM bridge: page translation through the map file, half-cycle CE/OE/WE strobes,
// write-data drive and a latched read copy.
module sram_dat_ctrl
  import sram_dat_pkg::*;
#(
  parameter logic [15:0] DatBase    = DAT_BASE,
  parameter bit          FixTopPage = 1'b1
) (
  input logic            cpuClockx2,
  input logic            n_reset,
  sram_dat_ctrl_if.slave bus
);

  dat_state_e       state_q, state_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             wdata_oe_q, wdata_oe_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;

  logic [3:0]       page;
  logic             dat_hit;
  logic             map_we;
  logic [PPN_W-1:0] tr_ppn, rb_ppn, ppn;

  assign page    = bus.cpu_addr[15:12];
  assign dat_hit = (bus.cpu_addr[15:4] == DatBase[15:4]);

  // cpuClock flips on every clk edge, so the next half-cycle is ~cpu_phase.
  always_comb begin
    state_d    = StIdle;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    wdata_oe_d = 1'b0;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    map_we     = 1'b0;

    if (!n_reset) begin
      wdata_d = '0;
      rdata_d = '0;
    end else begin
      state_d = bus.cpu_phase ? StStrobe : StSetup;
      if (state_d == StStrobe) begin
        // Map registers shadow SRAM: a DAT access never strobes the chip.
        if (dat_hit) begin
          map_we = ~bus.cpu_rw;
        end else if (bus.ext_sel) begin
          ce_n_d = 1'b0;
          if (bus.cpu_rw) begin
            oe_n_d = 1'b0;
          end else begin
            we_n_d     = 1'b0;
            wdata_oe_d = 1'b1;
            wdata_d    = bus.cpu_dout;
          end
        end
      end else if (state_q == StStrobe && !oe_n_q) begin
        rdata_d = bus.sram_rdata;
      end
    end
  end

  always_ff @(posedge cpuClockx2) begin
    state_q    <= state_d;
    ce_n_q     <= ce_n_d;
    oe_n_q     <= oe_n_d;
    we_n_q     <= we_n_d;
    wdata_oe_q <= wdata_oe_d;
    wdata_q    <= wdata_d;
    rdata_q    <= rdata_d;
  end

  dat_map_file #(
    .PpnW (PPN_W)
  ) u_map (
    .clk_i     (cpuClockx2),
    .n_reset_i (n_reset),
    .we_i      (map_we),
    .waddr_i   (bus.cpu_addr[3:0]),
    .wdata_i   (bus.cpu_dout[PPN_W-1:0]),
    .tr_idx_i  (page),
    .tr_ppn_o  (tr_ppn),
    .rb_idx_i  (bus.cpu_addr[3:0]),
    .rb_ppn_o  (rb_ppn)
  );

  // Page F can be pinned so vectors and I/O survive any map contents.
  assign ppn = (FixTopPage && page == 4'hF) ? PPN_W'(4'hF) : tr_ppn;

  assign bus.sram_addr     = {ppn, bus.cpu_addr[11:0]};
  assign bus.sram_ce_n     = ce_n_q;
  assign bus.sram_oe_n     = oe_n_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_wdata    = wdata_q;
  assign bus.sram_wdata_oe = wdata_oe_q;
  assign bus.cpu_rdata     = rdata_q;
  assign bus.dat_hit       = dat_hit;
  assign bus.dat_dout      = 8'(rb_ppn);

endmodule
